// File: rtl/uart_pkg.sv
// +------------------------------------------------------------+
// | uart_pkg: shared UART FSM state encodings and frame width  |
// | Revision: 1.0                                              |
// +------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// +------------------------------------------------------------+
// | uart_rx_fifo: receive byte FIFO, wrap-bit full/empty       |
// | Revision: 1.0                                              |
// +------------------------------------------------------------+
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] pushData,
  input  logic                      pop,
  output logic [UART_DATA_BITS-1:0] popData,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]               r_wrPtr;
  logic [AW:0]               r_rdPtr;
  logic [UART_DATA_BITS-1:0] r_mem [DEPTH];
  logic                      w_doPush;
  logic                      w_doPop;

  assign empty = (r_wrPtr == r_rdPtr);
  assign full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);

  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign w_doPush = push && (!full || pop);
  assign w_doPop  = pop && !empty;
  assign popData  = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= pushData;
  end

endmodule

`default_nettype wire

// File: rtl/uart_cpu_port.sv
// +------------------------------------------------------------+
// | uart_cpu_port: CPU-side 8N1 UART with RX FIFO and handshake |
// | Revision: 1.0                                              |
// +------------------------------------------------------------+
`default_nettype none

module uart_cpu_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 434,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      uartWriteReq,
  input  logic [UART_DATA_BITS-1:0] uartWriteData,
  output logic                      uartWriteReady,
  input  logic                      uartReadReq,
  output logic                      uartReadAck,
  output logic [UART_DATA_BITS-1:0] uartReadData,
  output logic                      txd,
  input  logic                      rxd,
  output logic                      rxOverflow,
  output logic                      rxFrameErr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // ---------------- transmitter ----------------
  tx_state_t                 r_txState, w_txNext;
  logic [CNT_W-1:0]          r_txCnt;
  logic [2:0]                r_txBitIdx;
  logic [UART_DATA_BITS-1:0] r_txShift;
  logic                      w_txBitEnd;

  assign w_txBitEnd = (r_txCnt == C_BIT_LAST);

  always_comb begin
    w_txNext       = r_txState;
    txd            = 1'b1;
    uartWriteReady = 1'b0;
    unique case (r_txState)
      TX_IDLE: begin
        uartWriteReady = 1'b1;
        if (uartWriteReq) w_txNext = TX_START;
      end
      TX_START: begin
        txd = 1'b0;
        if (w_txBitEnd) w_txNext = TX_DATA;
      end
      TX_DATA: begin
        txd = r_txShift[0];
        if (w_txBitEnd && r_txBitIdx == 3'd7) w_txNext = TX_STOP;
      end
      TX_STOP: begin
        if (w_txBitEnd) w_txNext = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_txState  <= TX_IDLE;
      r_txCnt    <= '0;
      r_txBitIdx <= '0;
      r_txShift  <= '0;
    end else begin
      r_txState <= w_txNext;
      if (r_txState == TX_IDLE) begin
        r_txCnt    <= '0;
        r_txBitIdx <= '0;
        if (uartWriteReq) r_txShift <= uartWriteData;
      end else begin
        r_txCnt <= w_txBitEnd ? '0 : r_txCnt + 1'b1;
        if (r_txState == TX_DATA && w_txBitEnd) begin
          r_txShift  <= r_txShift >> 1;
          r_txBitIdx <= r_txBitIdx + 1'b1;
        end
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t                 r_rxState, w_rxNext;
  logic                      r_rxSync1, r_rxSync2, r_rxPrev;
  logic [CNT_W-1:0]          r_rxCnt;
  logic [2:0]                r_rxBitIdx;
  logic [UART_DATA_BITS-1:0] r_rxShift;
  logic                      r_rxPush;
  logic                      r_rxOverflow;
  logic                      r_rxFrameErr;
  logic                      w_rxBitEnd;
  logic                      w_rxHalfEnd;
  logic                      w_rxFall;

  assign w_rxBitEnd  = (r_rxCnt == C_BIT_LAST);
  assign w_rxHalfEnd = (r_rxCnt == C_HALF_LAST);
  // Edge rather than level, so a low stop bit left on the line never restarts the FSM.
  assign w_rxFall    = r_rxPrev && !r_rxSync2;

  always_comb begin
    w_rxNext = r_rxState;
    unique case (r_rxState)
      RX_IDLE:  if (w_rxFall) w_rxNext = RX_START;
      RX_START: if (w_rxHalfEnd) w_rxNext = r_rxSync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rxBitEnd && r_rxBitIdx == 3'd7) w_rxNext = RX_STOP;
      RX_STOP:  if (w_rxBitEnd) w_rxNext = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxSync1    <= 1'b1;
      r_rxSync2    <= 1'b1;
      r_rxPrev     <= 1'b1;
      r_rxState    <= RX_IDLE;
      r_rxCnt      <= '0;
      r_rxBitIdx   <= '0;
      r_rxShift    <= '0;
      r_rxPush     <= 1'b0;
      r_rxFrameErr <= 1'b0;
    end else begin
      r_rxSync1    <= rxd;
      r_rxSync2    <= r_rxSync1;
      r_rxPrev     <= r_rxSync2;
      r_rxState    <= w_rxNext;
      r_rxPush     <= (r_rxState == RX_STOP) && w_rxBitEnd && r_rxSync2;
      r_rxFrameErr <= (r_rxState == RX_STOP) && w_rxBitEnd && !r_rxSync2;
      unique case (r_rxState)
        RX_IDLE: begin
          r_rxCnt    <= '0;
          r_rxBitIdx <= '0;
        end
        RX_START: r_rxCnt <= w_rxHalfEnd ? '0 : r_rxCnt + 1'b1;
        RX_DATA: begin
          r_rxCnt <= w_rxBitEnd ? '0 : r_rxCnt + 1'b1;
          if (w_rxBitEnd) begin
            r_rxShift  <= {r_rxSync2, r_rxShift[UART_DATA_BITS-1:1]};
            r_rxBitIdx <= r_rxBitIdx + 1'b1;
          end
        end
        RX_STOP: r_rxCnt <= w_rxBitEnd ? '0 : r_rxCnt + 1'b1;
      endcase
    end
  end

  // ---------------- FIFO and CPU read handshake ----------------
  logic [UART_DATA_BITS-1:0] w_fifoData;
  logic                      w_fifoFull;
  logic                      w_fifoEmpty;
  logic                      w_pop;
  logic                      r_ack;
  logic [UART_DATA_BITS-1:0] r_readData;

  assign w_pop = uartReadReq && !w_fifoEmpty && !r_ack;

  uart_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rxFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (r_rxPush),
    .pushData (r_rxShift),
    .pop      (w_pop),
    .popData  (w_fifoData),
    .full     (w_fifoFull),
    .empty    (w_fifoEmpty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack        <= 1'b0;
      r_readData   <= '0;
      r_rxOverflow <= 1'b0;
    end else begin
      r_ack        <= w_pop;
      r_rxOverflow <= r_rxPush && w_fifoFull && !w_pop;
      if (w_pop) r_readData <= w_fifoData;
    end
  end

  assign uartReadAck  = r_ack;
  assign uartReadData = r_readData;
  assign rxOverflow   = r_rxOverflow;
  assign rxFrameErr   = r_rxFrameErr;

endmodule

`default_nettype wire

// File: tb/tb_uart_cpu_port.sv
// +------------------------------------------------------------+
// | tb_uart_cpu_port: directed + random bench with frame model |
// | Revision: 1.0                                              |
// +------------------------------------------------------------+
`default_nettype none

module tb_uart_cpu_port;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       uartWriteReq = 1'b0;
  logic [7:0] uartWriteData = 8'h00;
  logic       uartWriteReady;
  logic       uartReadReq = 1'b0;
  logic       uartReadAck;
  logic [7:0] uartReadData;
  logic       txd;
  logic       rxd = 1'b1;
  logic       rxOverflow;
  logic       rxFrameErr;

  int errors = 0;
  int checks = 0;
  int ackCnt = 0, ovfCnt = 0, ferrCnt = 0, dblAck = 0;
  logic prevAck = 1'b0;
  logic [7:0] model[$];   // expected FIFO contents
  int expOvf = 0;

  uart_cpu_port #(
    .CLKS_PER_BIT  (CPB),
    .RX_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .uartWriteReq   (uartWriteReq),
    .uartWriteData  (uartWriteData),
    .uartWriteReady (uartWriteReady),
    .uartReadReq    (uartReadReq),
    .uartReadAck    (uartReadAck),
    .uartReadData   (uartReadData),
    .txd            (txd),
    .rxd            (rxd),
    .rxOverflow     (rxOverflow),
    .rxFrameErr     (rxFrameErr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (uartReadAck) ackCnt++;
    if (uartReadAck && prevAck) dblAck++;
    if (rxOverflow) ovfCnt++;
    if (rxFrameErr) ferrCnt++;
    prevAck = uartReadAck;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Write a byte and check the whole serial frame cycle by cycle.
  task automatic txFrame(input logic [7:0] d, input bit inject);
    logic [9:0] frame;
    frame = {1'b1, d, 1'b0};
    uartWriteReq  = 1'b1;
    uartWriteData = d;
    tick(1);
    uartWriteReq  = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (inject && b == 2 && c == 1) begin
          uartWriteReq  = 1'b1;
          uartWriteData = 8'h3C;
        end
        if (inject && b == 2 && c == 2) uartWriteReq = 1'b0;
        check($sformatf("txd[%02h] bit%0d c%0d", d, b, c), txd, frame[b]);
        check($sformatf("ready low [%02h] bit%0d c%0d", d, b, c), uartWriteReady, 1'b0);
        tick(1);
      end
    end
    check($sformatf("ready rise [%02h]", d), uartWriteReady, 1'b1);
  endtask

  // Drive one 8N1 frame on rxd and update the FIFO model.
  task automatic sendFrame(input logic [7:0] d, input bit stopBit);
    logic [9:0] frame;
    frame = {stopBit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rxd = frame[b];
      tick(CPB);
    end
    rxd = 1'b1;
    if (stopBit) begin
      if (model.size() < DEPTH) model.push_back(d);
      else expOvf++;
    end
  endtask

  task automatic readExpect(input string tag);
    logic [7:0] exp;
    bit got;
    exp = model.pop_front();
    got = 1'b0;
    uartReadReq = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (uartReadAck) got = 1'b1;
    end
    check({tag, " ack"}, got, 1'b1);
    check({tag, " data"}, uartReadData, exp);
    @(posedge clk);
    #1;
    uartReadReq = 1'b0;
  endtask

  task automatic expectNoAck(input string tag, input int n);
    int a0;
    a0 = ackCnt;
    uartReadReq = 1'b1;
    tick(n);
    uartReadReq = 1'b0;
    check(tag, ackCnt - a0, 0);
  endtask

  initial begin
    int o0, f0;
    bit idleOk;
    logic [7:0] rnd;

    // reset values
    tick(3);
    check("rst txd", txd, 1'b1);
    check("rst ready", uartWriteReady, 1'b1);
    check("rst ack", uartReadAck, 1'b0);
    check("rst rdata", uartReadData, 8'h00);
    check("rst ovf", rxOverflow, 1'b0);
    check("rst ferr", rxFrameErr, 1'b0);
    reset = 1'b1;
    tick(2);

    // transmit: A5 with an ignored write mid-frame, then random bytes
    txFrame(8'hA5, 1'b1);
    idleOk = 1'b1;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (txd !== 1'b1) idleOk = 1'b0;
      tick(1);
    end
    check("ignored write not sent", idleOk, 1'b1);
    for (int k = 0; k < 3; k++) begin
      rnd = 8'($urandom);
      txFrame(rnd, 1'b0);
      tick($urandom_range(0, 3));
    end

    // receive one byte, then an empty-FIFO request must wait
    sendFrame(8'h5A, 1'b1);
    readExpect("rx 5A");
    expectNoAck("no ack on empty", 40);

    // five back-to-back frames into a four-entry FIFO
    o0 = ovfCnt;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) check("no ovf before frame5", ovfCnt - o0, 0);
      sendFrame(8'(k), 1'b1);
    end
    tick(8);
    check("ovf pulses", ovfCnt - o0, expOvf);
    for (int k = 0; k < 4; k++) readExpect($sformatf("drain %0d", k));
    expectNoAck("no ack after drain", 40);

    // bad stop bit, then a one-cycle glitch
    o0 = ovfCnt;
    f0 = ferrCnt;
    sendFrame(8'hFF, 1'b0);
    tick(8);
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(20);
    check("frame err pulses", ferrCnt - f0, 1);
    check("no ovf on ferr", ovfCnt - o0, 0);
    expectNoAck("no push after ferr/glitch", 30);

    // random receive traffic with interleaved reads
    for (int k = 0; k < 4; k++) begin
      sendFrame(8'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 1) readExpect($sformatf("rand rx %0d", k));
    end
    while (model.size() > 0) readExpect("rand drain");

    // reset during a transmit frame
    uartWriteReq  = 1'b1;
    uartWriteData = 8'($urandom);
    tick(1);
    uartWriteReq  = 1'b0;
    tick(9);
    check("pre-reset txd active", uartWriteReady, 1'b0);
    reset = 1'b0;
    #1;
    check("mid reset txd", txd, 1'b1);
    check("mid reset ready", uartWriteReady, 1'b1);
    tick(2);
    reset = 1'b1;
    tick(2);
    txFrame(8'h00, 1'b0);

    check("no double ack", dblAck, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_cpu_port.md
# uart_cpu_port

CPU-facing UART peripheral: the responder end of the CPU's `uartRead*` / `uartWrite*` handshakes.
- Serializes bytes written by the CPU onto `txd` as 8N1 frames.
- Deserializes 8N1 frames from `rxd` into a small FIFO that the CPU drains through the read handshake.
- Sits beside `PhysicalRAM` at top level; wires port-for-port to the CPU's UART pins.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200); legal range ≥ 4.
- `RX_FIFO_DEPTH`, 4, receive FIFO entries; must be a power of two ≥ 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `uartWriteReq`  in  1  CPU request to transmit `uartWriteData`.
- `uartWriteData`  in  8  byte to transmit.
- `uartWriteReady`  out  1  transmitter can accept a byte.
- `uartReadReq`  in  1  CPU requests one received byte.
- `uartReadAck`  out  1  one-cycle strobe: `uartReadData` is valid.
- `uartReadData`  out  8  received byte.
- `txd`  out  1  serial output, idle high.
- `rxd`  in  1  serial input, asynchronous to `clk`.
- `rxOverflow`  out  1  one-cycle pulse when a received byte is dropped because the FIFO is full.
- `rxFrameErr`  out  1  one-cycle pulse when a frame is dropped for a bad stop bit.

## Operation
Write path:
- A byte is accepted on a rising edge where `uartWriteReq && uartWriteReady`.
- `uartWriteReq` while `uartWriteReady` is low is ignored; there is no queueing.
- TX FSM: TX_IDLE → TX_START (`txd`=0) → TX_DATA (8 bits, LSB first) → TX_STOP (`txd`=1) → TX_IDLE.
- Each bit lasts exactly `CLKS_PER_BIT` cycles.
- `uartWriteReady` is high only in TX_IDLE.

Read path:
- `rxd` passes through a two-flop synchronizer before any use.
- RX FSM: RX_IDLE → RX_START on a synchronized falling edge.
- RX_START re-samples at `CLKS_PER_BIT/2`. Still low: go to RX_DATA. High: treat as a glitch and return to RX_IDLE.
- RX_DATA samples 8 bits at bit centres, LSB first.
- RX_STOP samples the stop bit at its centre:
  - 1: push the byte to the FIFO, or pulse `rxOverflow` if the FIFO is full (byte dropped, FIFO unchanged).
  - 0: pulse `rxFrameErr` and drop the byte.
- After the stop sample the FSM goes to RX_IDLE immediately, so a back-to-back start bit is caught.

CPU read handshake:
- The CPU holds `uartReadReq` high until it sees `uartReadAck`.
- On a cycle where `uartReadReq` is high, the FIFO is non-empty and `uartReadAck` was low the previous cycle:
  - the next edge pops the head entry into the `uartReadData` register;
  - `uartReadAck` is driven high for exactly one cycle.
- FIFO empty: the request waits with no timeout. Ack follows the first push by one cycle.
- `uartReadAck` is never high on two consecutive cycles.
- `uartReadData` holds its value until the next Ack.

Simultaneous push and pop on one edge:
- Both happen; occupancy is unchanged.
- A push into a full FIFO in the same cycle as a pop succeeds; no overflow.

FIFO pointers are `$clog2(RX_FIFO_DEPTH)+1` bits and wrap modulo 2×depth. Full/empty are decided by the MSB compare.

## Timing
Reset values (asynchronous, while `reset`=0):
- `txd`=1, `uartWriteReady`=1, `uartReadAck`=0, `uartReadData`=8'h00.
- `rxOverflow`=0, `rxFrameErr`=0.
- FIFO empty; both FSMs idle; synchronizer flops reset to 1.

Transmit timing:
- Write accepted at edge N: `uartWriteReady` is low and `txd`=0 from N+1.
- The frame occupies 10×`CLKS_PER_BIT` cycles.
- `uartWriteReady` rises at edge N+1+10×`CLKS_PER_BIT`.
- A new write is accepted no earlier than that edge.

Receive and read timing:
- `rxd` falling edge to FSM start: 2 cycles of synchronizer latency.
- Stop-bit centre sample to FIFO push: 1 cycle.
- Read latency: Req seen with data available → Ack at the next edge.

Reset asserted mid-frame:
- Returns to the reset values immediately.
- An in-flight TX frame is truncated with `txd`=1.
- A partial RX byte is discarded.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` (TX_IDLE, TX_START, TX_DATA, TX_STOP);
  - `rx_state_t` (RX_IDLE, RX_START, RX_DATA, RX_STOP);
  - `UART_DATA_BITS`=8.
- Sub-module `uart_rx_fifo` (parameter DEPTH; ports push/pop/data/full/empty), instantiated once.
- TX, RX and handshake logic live in `uart_cpu_port`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `RX_FIFO_DEPTH`=4.
- Write 8'hA5 while Ready=1 → Ready drops next cycle; `txd` shows 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; Ready rises exactly 40 cycles after the first low cycle.
- Req with 8'h3C during an active frame → ignored; the frame in progress continues unchanged; 8'h3C is never transmitted.
- Drive frame 8'h5A on `rxd`, then hold `uartReadReq` high → one-cycle Ack with `uartReadData`=8'h5A; with Req still held, no second Ack while the FIFO is empty.
- Receive 5 back-to-back frames 8'h01..8'h05 with no reads → `rxOverflow` pulses once, on frame 5; four reads return 01, 02, 03, 04, then Req waits.
- Frame 8'hFF with stop bit 0, then a 1-cycle low glitch on `rxd` → `rxFrameErr` pulses once; no push; the glitch produces no activity.
- Assert `reset` low at cycle 10 of a TX frame → `txd`=1 and Ready=1 within the same cycle; a fresh write of 8'h00 afterwards transmits a correct frame.
